// File: rtl/calendar_date_counter_pkg.sv
// Shared types and constants for the BCD day/month calendar counter.
// Months and days are packed BCD: month = {tens, ones}, day = {tens[1:0], ones}.
package calendar_pkg;

  typedef logic [4:0] bcd_month_t;
  typedef logic [5:0] bcd_day_t;

  typedef struct packed {
    logic       month_t;
    logic [3:0] month_o;
    logic [1:0] day_t;
    logic [3:0] day_o;
  } bcd_date_t;

  typedef enum logic [1:0] {
    ACT_HOLD,
    ACT_ADVANCE,
    ACT_LOAD,
    ACT_REJECT
  } date_action_t;

  localparam bcd_month_t MONTH_JAN = 5'h01;
  localparam bcd_month_t MONTH_FEB = 5'h02;
  localparam bcd_month_t MONTH_APR = 5'h04;
  localparam bcd_month_t MONTH_JUN = 5'h06;
  localparam bcd_month_t MONTH_SEP = 5'h09;
  localparam bcd_month_t MONTH_NOV = 5'h11;
  localparam bcd_month_t MONTH_DEC = 5'h12;

  localparam bcd_day_t DAY_FIRST     = 6'h01;
  localparam bcd_day_t DAYS_31       = 6'h31;
  localparam bcd_day_t DAYS_30       = 6'h30;
  localparam bcd_day_t DAYS_FEB      = 6'h28;
  localparam bcd_day_t DAYS_FEB_LEAP = 6'h29;

  localparam bcd_date_t DATE_RESET = '{month_t: 1'b0, month_o: 4'd1,
                                       day_t: 2'd0, day_o: 4'd1};

  function automatic bcd_month_t date_month(input bcd_date_t d);
    return {d.month_t, d.month_o};
  endfunction

  function automatic bcd_day_t date_day(input bcd_date_t d);
    return {d.day_t, d.day_o};
  endfunction

  function automatic bcd_date_t make_date(input bcd_month_t m, input bcd_day_t d);
    bcd_date_t r;
    r.month_t = m[4];
    r.month_o = m[3:0];
    r.day_t   = d[5:4];
    r.day_o   = d[3:0];
    return r;
  endfunction

  // True for 01..09 and 10..12 with legal BCD ones digit.
  function automatic logic month_valid(input bcd_month_t m);
    return (!m[4] && (m[3:0] != 4'd0) && (m[3:0] <= 4'd9)) ||
           ( m[4] && (m[3:0] <= 4'd2));
  endfunction

  function automatic bcd_month_t bcd_inc_month(input bcd_month_t m);
    return (m[3:0] == 4'd9) ? 5'h10 : {m[4], m[3:0] + 4'd1};
  endfunction

  function automatic bcd_day_t bcd_inc_day(input bcd_day_t d);
    return (d[3:0] == 4'd9) ? {d[5:4] + 2'd1, 4'd0} : {d[5:4], d[3:0] + 4'd1};
  endfunction

endpackage

// File: rtl/calendar_date_counter_month_length_lut.sv
// Combinational month-length table: BCD month plus leap flag -> last day (BCD).
// Out-of-range month codes fall through to 31; callers validate the month separately.
module month_length_lut
  import calendar_pkg::*;
(
  input  bcd_month_t month,
  input  logic       is_leap,
  output bcd_day_t   last_day
);

  always_comb begin
    // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
    last_day = DAYS_31;
    case (month)
      MONTH_FEB: last_day = is_leap ? DAYS_FEB_LEAP : DAYS_FEB;
      MONTH_APR,
      MONTH_JUN,
      MONTH_SEP,
      MONTH_NOV: last_day = DAYS_30;
      default:   last_day = DAYS_31;
    endcase
  end

endmodule

// File: rtl/calendar_date_counter.sv
// BCD day/month calendar: one day per enabled clock, validated loads, and a
// registered year-rollover pulse that clocks the external leap-year counter.
module calendar_date_counter
  import calendar_pkg::*;
#(
  parameter logic [1:0]  LEAP_CODE   = 2'b00,
  parameter int unsigned PULSE_WIDTH = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] leap_q,
  input  logic       set,
  input  logic       set_month_t,
  input  logic [3:0] set_month_o,
  input  logic [1:0] set_day_t,
  input  logic [3:0] set_day_o,
  output logic       month_t,
  output logic [3:0] month_o,
  output logic [1:0] day_t,
  output logic [3:0] day_o,
  output logic       year_pulse,
  output logic       set_err
);

  localparam logic [3:0] PULSE_LOAD = 4'(PULSE_WIDTH);

  bcd_date_t    date_q;
  bcd_date_t    date_d;
  date_action_t action;
  logic         rollover;
  logic         is_leap;
  logic         load_ok;
  logic [3:0]   pulse_cnt;

  bcd_month_t   cur_month;
  bcd_day_t     cur_day;
  bcd_day_t     cur_last;
  bcd_month_t   set_month;
  bcd_day_t     set_day;
  bcd_day_t     set_last;

  assign is_leap   = (leap_q == LEAP_CODE);
  assign cur_month = date_month(date_q);
  assign cur_day   = date_day(date_q);
  assign set_month = {set_month_t, set_month_o};
  assign set_day   = {set_day_t, set_day_o};

  month_length_lut u_run_len (
    .month    (cur_month),
    .is_leap  (is_leap),
    .last_day (cur_last)
  );

  month_length_lut u_set_len (
    .month    (set_month),
    .is_leap  (is_leap),
    .last_day (set_last)
  );

  // BCD compares numerically once both digits are legal, so plain <= works.
  assign load_ok = month_valid(set_month) && (set_day_o <= 4'd9) &&
                   (set_day != 6'h00) && (set_day <= set_last);

  always_comb begin
    action = ACT_HOLD;
    if (set) begin
      action = load_ok ? ACT_LOAD : ACT_REJECT;
    end else if (en) begin
      action = ACT_ADVANCE;
    end
  end

  always_comb begin
    date_d   = date_q;
    rollover = 1'b0;
    case (action)
      ACT_LOAD: date_d = make_date(set_month, set_day);
      ACT_ADVANCE: begin
        if (cur_day != cur_last) begin
          date_d = make_date(cur_month, bcd_inc_day(cur_day));
        end else if (cur_month != MONTH_DEC) begin
          date_d = make_date(bcd_inc_month(cur_month), DAY_FIRST);
        end else begin
          date_d   = make_date(MONTH_JAN, DAY_FIRST);
          rollover = 1'b1;
        end
      end
      default: date_d = date_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      date_q     <= DATE_RESET;
      set_err    <= 1'b0;
      pulse_cnt  <= 4'd0;
      year_pulse <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register updates from the pre-edge values.
      date_q  <= date_d;
      set_err <= (action == ACT_REJECT);
      // pulse_cnt holds the cycles still owed including the current one;
      // a rollover always restarts it.
      if (rollover) begin
        pulse_cnt  <= PULSE_LOAD;
        year_pulse <= 1'b1;
      end else begin
        if (pulse_cnt != 4'd0) begin
          pulse_cnt <= pulse_cnt - 4'd1;
        end
        year_pulse <= (pulse_cnt > 4'd1);
      end
    end
  end

  assign month_t = date_q.month_t;
  assign month_o = date_q.month_o;
  assign day_t   = date_q.day_t;
  assign day_o   = date_q.day_o;

endmodule

// File: doc/calendar_date_counter.md
Name: calendar_date_counter

Overview:
- Day/month calendar counter that advances one day per `en` tick.
- Consumes the 2-bit year-mod-4 count from the leap-year counter to size February.
- Produces the registered year-rollover pulse that drives that counter's enable input.
- Sits between the day-tick divider and the 7-segment display path; all outputs are BCD.

Parameters:
- LEAP_CODE, 2'b00: value of `leap_q` that denotes a leap year.
- PULSE_WIDTH, 1: clk cycles `year_pulse` stays high per rollover; legal range 1..15.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset
- en  input  1  day-advance request, sampled each clk edge; level-sensitive, one day per cycle while high
- leap_q  input  2  year-mod-4 count from the leap-year counter
- set  input  1  load request for `set_month`/`set_day`
- set_month_t  input  1  BCD month tens
- set_month_o  input  4  BCD month ones
- set_day_t  input  2  BCD day tens
- set_day_o  input  4  BCD day ones
- month_t  output  1  BCD month tens
- month_o  output  4  BCD month ones
- day_t  output  2  BCD day tens
- day_o  output  4  BCD day ones
- year_pulse  output  1  registered rollover pulse, feeds the leap-year counter's enable
- set_err  output  1  one-cycle flag: rejected load

Behaviour:
- **Reset (rst=0, async):**
  - date = 01/01: month_t=0, month_o=1, day_t=0, day_o=1.
  - year_pulse=0, set_err=0, pulse counter=0.
  - Takes effect immediately, mid-count or mid-pulse included; any in-flight pulse is truncated.
- **Last day of month** (combinational from current month and leap_q):
  - Feb: 29 if leap_q==LEAP_CODE, else 28.
  - Apr, Jun, Sep, Nov: 30.
  - All other months: 31.
- **Advance (en=1, set=0), one clk edge, zero added latency:**
  - day != last: day_o increments. On day_o 9 -> 0, day_t increments.
  - day == last, month != 12: day -> 01, month increments. On month 09 -> 10, month_t=1, month_o=0.
  - day == last, month == 12 (i.e. 12/31): date -> 01/01 and the rollover pulse starts.
- **year_pulse:**
  - Registered; goes high on the same edge that writes 01/01 and stays high exactly PULSE_WIDTH cycles.
  - Glitch-free, so it is safe to use as a clock-like enable downstream.
  - Rollover during an active pulse (only possible with PULSE_WIDTH > days per year; unreachable in legal range) restarts the count.
- **leap_q timing:**
  - leap_q is sampled combinationally every cycle; no internal copy.
  - After a rollover, the new leap_q is valid by Feb, so no hazard exists.
- **Load (set=1), priority over en; en in the same cycle is dropped:**
  - Valid load requires: month in 1..12, BCD digits <= 9, day in 1..last(set month, current leap_q).
  - Valid: date loads on that edge, set_err=0.
  - Invalid: date unchanged, set_err=1 for one cycle.
  - A load never generates year_pulse.
- **Idle:** en=0 and set=0 holds state; set_err returns to 0.
- Outputs change only on clk edges or reset; no combinational path from inputs to outputs.

Decomposition:
- Shared package `calendar_pkg`:
  - month constants MONTH_FEB=2, MONTH_DEC=12;
  - DAYS_31, DAYS_30, DAYS_FEB, DAYS_FEB_LEAP as BCD constants;
  - function/typedef for a BCD date {month_t, month_o, day_t, day_o}.
- One sub-module, `month_length_lut`: combinational (month BCD, is_leap) -> last-day BCD.
  - Instantiated twice: once for the running date, once for load validation.

Test Plan:
- **Reset:** rst=0 then 1 → outputs read 01/01, year_pulse=0, set_err=0. Assert rst mid-pulse → pulse drops in the same cycle.
- **Month walk:** leap_q=01, en=1 from 01/01 for 58 cycles → reaches 02/28. Next cycle → 03/01. No year_pulse.
- **Leap Feb:**
  - leap_q=00, load 02/28, one en → 02/29; one more → 03/01.
  - Repeat with leap_q=10 → 02/28 goes to 03/01.
- **Year rollover:**
  - Load 12/31, one en → 01/01 and year_pulse high exactly 1 cycle.
  - PULSE_WIDTH=3 → high exactly 3 cycles.
  - Connect the leap-year counter: 4 rollovers → leap_q sequence 01, 10, 11, 00.
- **Load validation:**
  - set with 04/31 → set_err=1, date unchanged.
  - 13/01 → err.
  - 02/29 with leap_q=01 → err; with leap_q=00 → loads.
  - 00/05 → err.
- **Priority:** set=1 and en=1 together loading 06/15 → date = 06/15, not 06/16. Holding en=1 over 365 consecutive cycles from 01/01 (non-leap) → back to 01/01 with exactly one pulse.
